led_blink_multi: RTL

- Parametrised multi-channel LED blinker and successor to the fixed four-LED blinker; runs on the 25 MHz board clock.
- Each channel has a runtime-programmable half-period and mode: OFF, ON, BLINK, or BURST, where BURST gives N blinks then stops.
- A global sync pulse phase-aligns all channels.
- Per-channel tick outputs let downstream logic share the derived rates.

---
 rtl/led_blink_multi.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/led_blink_multi.sv
// ---------------------------------------------------------------------------
// led_blink_multi
//
// Multi-channel LED blinker. Each channel has a runtime-programmable
// half-period and one of four modes: OFF, ON, BLINK or BURST. BURST gives a
// fixed number of high pulses and then parks the channel in a DONE state.
// A global sync pulse phase-aligns every blinking channel. Each channel also
// exports a one-cycle tick on every LED toggle so other logic can reuse the
// derived rate.
//
// Optional feature: define LED_BLINK_DIM_EN to add the i_Dim brightness
// input. This adds a free-running 4-bit PWM that gates o_LED. The gating adds
// one cycle of latency to o_LED only.
//
// Parameters:
//   g_NUM_CH     number of LED channels (1..16)
//   g_CNT_WIDTH  width of the half-period register and counter
//   g_BASE_HALF  half-period every channel gets out of reset
//   g_BURST_CNT  number of high pulses in BURST mode (1..255)
//
// Ports:
//   i_Clk         system clock
//   i_Rst_L       synchronous active-low reset
//   i_Wr_En       single-cycle config write strobe
//   i_Wr_Ch       target channel; out-of-range indices are ignored
//   i_Wr_Mode     00 OFF, 01 ON, 10 BLINK, 11 BURST
//   i_Wr_Half     half-period in clocks (0 behaves as 1)
//   i_Sync        phase-align pulse for all BLINK/BURST channels
//   i_Dim         (LED_BLINK_DIM_EN only) brightness, 15 = full on
//   o_LED         LED drive, bit k = channel k
//   o_Tick        one-cycle pulse on every LED toggle
//   o_Burst_Done  level, high once a BURST has completed
// ---------------------------------------------------------------------------
module led_blink_multi #(
  parameter int g_NUM_CH    = 4,
  parameter int g_CNT_WIDTH = 24,
  parameter int g_BASE_HALF = 1250000,
  parameter int g_BURST_CNT = 3,
  localparam int c_CH_W     = (g_NUM_CH > 1) ? $clog2(g_NUM_CH) : 1
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_L,
  input  logic                   i_Wr_En,
  input  logic [c_CH_W-1:0]      i_Wr_Ch,
  input  logic [1:0]             i_Wr_Mode,
  input  logic [g_CNT_WIDTH-1:0] i_Wr_Half,
  input  logic                   i_Sync,
`ifdef LED_BLINK_DIM_EN
  input  logic [3:0]             i_Dim,
`endif
  output logic [g_NUM_CH-1:0]    o_LED,
  output logic [g_NUM_CH-1:0]    o_Tick,
  output logic [g_NUM_CH-1:0]    o_Burst_Done
);

  localparam logic [g_CNT_WIDTH-1:0] c_ONE       = g_CNT_WIDTH'(1);
  localparam logic [g_CNT_WIDTH-1:0] c_BASE_HALF = g_CNT_WIDTH'(g_BASE_HALF);
  localparam logic [7:0]             c_BURST     = 8'(g_BURST_CNT);

  // DONE is a separate state so a finished burst stays parked until a write,
  // sync or reset restarts it.
  typedef enum logic [2:0] {
    CH_OFF,
    CH_ON,
    CH_BLINK,
    CH_BURST,
    CH_DONE
  } ch_state_t;

  logic [g_NUM_CH-1:0]    led_raw;
  logic [g_NUM_CH-1:0]    tick_raw;
  logic [g_NUM_CH-1:0]    done_raw;
  logic [g_CNT_WIDTH-1:0] wr_half_eff;

  // A programmed half-period of 0 is treated as 1 so the counter always has
  // a valid terminal value.
  assign wr_half_eff = (i_Wr_Half == '0) ? c_ONE : i_Wr_Half;

  for (genvar k = 0; k < g_NUM_CH; k++) begin : g_ch
    ch_state_t              state_q, state_d;
    logic [g_CNT_WIDTH-1:0] half_q, half_d;
    logic [g_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [7:0]             rem_q, rem_d;
    logic                   led_q, led_d;
    logic                   tick_q, tick_d;
    logic                   done_q, done_d;
    logic                   wr_hit;
    logic                   running;
    logic                   terminal;

    // Out-of-range channel indices never match any k, so they are dropped.
    assign wr_hit   = i_Wr_En && (i_Wr_Ch == c_CH_W'(k));
    assign running  = (state_q == CH_BLINK) || (state_q == CH_BURST) ||
                      (state_q == CH_DONE);
    // >= rather than == keeps the counter bounded even if it were ever ahead.
    assign terminal = (cnt_q >= (half_q - c_ONE));

    // State register plus the channel datapath registers.
    always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
        state_q <= CH_BLINK;
        half_q  <= c_BASE_HALF;
        cnt_q   <= '0;
        rem_q   <= c_BURST;
        led_q   <= 1'b0;
        tick_q  <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        half_q  <= half_d;
        cnt_q   <= cnt_d;
        rem_q   <= rem_d;
        led_q   <= led_d;
        tick_q  <= tick_d;
        done_q  <= done_d;
      end
    end

    // Next-state logic: a write beats sync, sync beats normal counting.
    always_comb begin
      state_d = state_q;
      if (wr_hit) begin
        case (i_Wr_Mode)
          2'b00:   state_d = CH_OFF;
          2'b01:   state_d = CH_ON;
          2'b10:   state_d = CH_BLINK;
          default: state_d = CH_BURST;
        endcase
      end else if (i_Sync && running) begin
        state_d = (state_q == CH_BLINK) ? CH_BLINK : CH_BURST;
      end else if ((state_q == CH_BURST) && terminal && led_q &&
                   (rem_q == 8'd1)) begin
        state_d = CH_DONE;
      end
    end

    // Datapath next values. The last falling toggle of a burst still ticks,
    // since the LED does change on that edge.
    always_comb begin
      half_d = half_q;
      cnt_d  = cnt_q;
      rem_d  = rem_q;
      led_d  = led_q;
      tick_d = 1'b0;
      done_d = done_q;
      if (wr_hit) begin
        half_d = wr_half_eff;
        cnt_d  = '0;
        rem_d  = c_BURST;
        led_d  = (i_Wr_Mode == 2'b01);
        done_d = 1'b0;
      end else if (i_Sync && running) begin
        cnt_d  = '0;
        rem_d  = c_BURST;
        led_d  = 1'b0;
        done_d = 1'b0;
      end else begin
        case (state_q)
          CH_OFF: begin
            cnt_d = '0;
            led_d = 1'b0;
          end
          CH_ON: begin
            cnt_d = '0;
            led_d = 1'b1;
          end
          CH_BLINK: begin
            if (terminal) begin
              cnt_d  = '0;
              led_d  = ~led_q;
              tick_d = 1'b1;
            end else begin
              cnt_d = cnt_q + c_ONE;
            end
          end
          CH_BURST: begin
            if (terminal) begin
              cnt_d  = '0;
              tick_d = 1'b1;
              if (led_q) begin
                led_d = 1'b0;
                rem_d = rem_q - 8'd1;
                if (rem_q == 8'd1) begin
                  done_d = 1'b1;
                end
              end else begin
                led_d = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + c_ONE;
            end
          end
          default: begin
            cnt_d  = '0;
            led_d  = 1'b0;
            done_d = 1'b1;
          end
        endcase
      end
    end

    assign led_raw[k]  = led_q;
    assign tick_raw[k] = tick_q;
    assign done_raw[k] = done_q;
  end

  assign o_Tick       = tick_raw;
  assign o_Burst_Done = done_raw;

`ifdef LED_BLINK_DIM_EN
  logic [3:0]          pwm_cnt;
  logic [g_NUM_CH-1:0] led_dim_q;

  // Free-running PWM; a channel is lit for the first i_Dim+1 of 16 slots.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      pwm_cnt   <= 4'd0;
      led_dim_q <= '0;
    end else begin
      pwm_cnt   <= pwm_cnt + 4'd1;
      led_dim_q <= led_raw & {g_NUM_CH{pwm_cnt <= i_Dim}};
    end
  end

  assign o_LED = led_dim_q;
`else
  assign o_LED = led_raw;
`endif

endmodule
